// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - product stream in, packet result out, for the MAC accumulator
// The master side feeds products and takes results; the slave side is the accumulator.
interface mac_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
);
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_last;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  cnt_out;
  logic              ovf_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output prod_in, prod_valid, prod_last, out_ready,
    input  prod_ready, acc_out, cnt_out, ovf_out, out_valid
  );

  modport slave (
    input  prod_in, prod_valid, prod_last, out_ready,
    output prod_ready, acc_out, cnt_out, ovf_out, out_valid
  );
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - signed product accumulator emitting one dot-product per packet
// Sums sign-extended products per packet, with optional saturation and a sticky overflow flag.
module mac_accumulator #(
  parameter int PROD_W   = 64,
  parameter int ACC_W    = 72,
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mac_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t                   state, state_nx;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_sext;
  logic signed [ACC_W-1:0]  acc, acc_nx, clamp;
  logic signed [ACC_W:0]    sum_w;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic                     ovf, ovf_nx;
  logic                     ready, accept, overflow;

  assign prod_s    = bus.prod_in;
  assign prod_sext = ACC_W'(prod_s);
  assign ready     = (state != DONE);
  assign accept    = bus.prod_valid & ready;

  // One guard bit: overflow whenever the guard and the ACC_W sign disagree.
  assign sum_w    = {acc[ACC_W-1], acc} + {prod_sext[ACC_W-1], prod_sext};
  assign overflow = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign clamp    = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_nx = bus.prod_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.prod_ready = ready & ~rst;
    bus.out_valid  = (state == DONE);
    bus.acc_out    = acc;
    bus.cnt_out    = cnt;
    bus.ovf_out    = ovf;
  end

  always_comb begin
    acc_nx = acc;
    cnt_nx = cnt;
    ovf_nx = ovf;
    if (accept) begin
      if (state == IDLE) begin
        acc_nx = prod_sext;
        cnt_nx = CNT_W'(1);
        ovf_nx = 1'b0;
      end else begin
        acc_nx = sum_w[ACC_W-1:0];
        if (overflow) begin
          ovf_nx = 1'b1;
          if (SATURATE) begin
            acc_nx = clamp;
          end
        end
        if (cnt != {CNT_W{1'b1}}) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      ovf <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed vector bench for mac_accumulator
// One 72-bit saturating instance plus 64-bit saturating and wrapping instances fed in lockstep.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_accumulator_if #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) mif ();
  mac_accumulator_if #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) sif ();
  mac_accumulator_if #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) wif ();

  mac_accumulator #(.PROD_W(64), .ACC_W(72), .CNT_W(16), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(mif.slave));
  mac_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .bus(sif.slave));
  mac_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(16), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .bus(wif.slave));

  logic [63:0] p64_in;
  logic        p64_valid, p64_last, p64_oready;
  assign sif.prod_in    = p64_in;
  assign sif.prod_valid = p64_valid;
  assign sif.prod_last  = p64_last;
  assign sif.out_ready  = p64_oready;
  assign wif.prod_in    = p64_in;
  assign wif.prod_valid = p64_valid;
  assign wif.prod_last  = p64_last;
  assign wif.out_ready  = p64_oready;

  typedef struct {
    logic signed [63:0] prod;
    logic               last;
    int                 gap;
    logic signed [71:0] acc;
    logic [15:0]        cnt;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    logic        last;
    logic [63:0] acc_s;
    logic [63:0] acc_w;
    logic        ovf;
  } vec64_t;

  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(longint p, bit l, int g, longint a, int c);
    vec_t v;
    v.prod = p;
    v.last = l;
    v.gap  = g;
    v.acc  = 72'(a);
    v.cnt  = 16'(c);
    return v;
  endfunction

  function automatic vec64_t mk64(logic [63:0] p, bit l, logic [63:0] s, logic [63:0] w, bit o);
    vec64_t v;
    v.prod  = p;
    v.last  = l;
    v.acc_s = s;
    v.acc_w = w;
    v.ovf   = o;
    return v;
  endfunction

  task automatic check(string name, logic [71:0] got, logic [71:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t v);
    int n;
    mif.prod_in    = v.prod;
    mif.prod_last  = v.last;
    mif.prod_valid = 1'b1;
    n = 0;
    while (mif.prod_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("ready_timeout", 72'd0, 72'd1);
    step();
    check("acc", mif.acc_out, v.acc);
    check("cnt", 72'(mif.cnt_out), 72'(v.cnt));
    check("ovf", 72'(mif.ovf_out), 72'd0);
    check("out_valid", 72'(mif.out_valid), 72'(v.last));
    mif.prod_valid = 1'b0;
    mif.prod_last  = 1'b1;
    for (int g = 0; g < v.gap; g++) begin
      step();
      check("gap_acc", mif.acc_out, v.acc);
      check("gap_cnt", 72'(mif.cnt_out), 72'(v.cnt));
      check("gap_out_valid", 72'(mif.out_valid), 72'd0);
    end
  endtask

  task automatic apply64(vec64_t v);
    int n;
    p64_in    = v.prod;
    p64_last  = v.last;
    p64_valid = 1'b1;
    n = 0;
    while (sif.prod_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("ready64_timeout", 72'd0, 72'd1);
    step();
    check("sat_acc", 72'(sif.acc_out), 72'(v.acc_s));
    check("wrap_acc", 72'(wif.acc_out), 72'(v.acc_w));
    check("sat_ovf", 72'(sif.ovf_out), 72'(v.ovf));
    check("wrap_ovf", 72'(wif.ovf_out), 72'(v.ovf));
    check("sat_out_valid", 72'(sif.out_valid), 72'(v.last));
    p64_valid = 1'b0;
  endtask

  vec_t   tbl[$];
  vec64_t tbl64[$];
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  initial begin
    mif.prod_in = '0;  mif.prod_valid = 1'b0; mif.prod_last = 1'b0; mif.out_ready = 1'b1;
    p64_in = '0; p64_valid = 1'b0; p64_last = 1'b0; p64_oready = 1'b1;

    tbl.push_back(mk(-2000,    0, 0, -2000,    1));
    tbl.push_back(mk(6300,     0, 0, 4300,     2));
    tbl.push_back(mk(5200,     0, 0, 9500,     3));
    tbl.push_back(mk(-3250,    1, 0, 6250,     4));
    tbl.push_back(mk(98765,    1, 0, 98765,    1));
    tbl.push_back(mk(-1000000, 0, 0, -1000000, 1));
    tbl.push_back(mk(-998001,  1, 0, -1998001, 2));
    tbl.push_back(mk(50,       0, 3, 50,       1));
    tbl.push_back(mk(-40,      0, 3, 10,       2));
    tbl.push_back(mk(0,        1, 0, 10,       3));

    tbl64.push_back(mk64(MAX64,         0, MAX64, MAX64, 0));
    tbl64.push_back(mk64(64'd1,         1, MAX64, MIN64, 1));
    tbl64.push_back(mk64(64'd0,         1, 64'd0, 64'd0, 0));
    tbl64.push_back(mk64(MIN64,         0, MIN64, MIN64, 0));
    tbl64.push_back(mk64(64'hFFFF_FFFF_FFFF_FFFF, 1, MIN64, MAX64, 1));
    tbl64.push_back(mk64(MAX64,         0, MAX64, MAX64, 0));
    tbl64.push_back(mk64(64'd1,         0, MAX64, MIN64, 1));
    tbl64.push_back(mk64(-64'sd5,       1, 64'h7FFF_FFFF_FFFF_FFFA, 64'h7FFF_FFFF_FFFF_FFFB, 1));

    step();
    step();
    check("rst_prod_ready", 72'(mif.prod_ready), 72'd0);
    check("rst_out_valid", 72'(mif.out_valid), 72'd0);
    check("rst_acc", mif.acc_out, 72'd0);
    check("rst_cnt", 72'(mif.cnt_out), 72'd0);
    check("rst_ovf", 72'(mif.ovf_out), 72'd0);
    rst = 1'b0;
    step();
    check("rel_prod_ready", 72'(mif.prod_ready), 72'd1);

    foreach (tbl[i]) apply(tbl[i]);

    // Backpressure: result held, offered product waits for the next packet.
    step();
    mif.out_ready = 1'b0;
    apply(mk(7, 1, 0, 7, 1));
    mif.prod_in = 64'd11; mif.prod_last = 1'b1; mif.prod_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_out_valid", 72'(mif.out_valid), 72'd1);
      check("bp_prod_ready", 72'(mif.prod_ready), 72'd0);
      check("bp_acc", mif.acc_out, 72'd7);
      check("bp_cnt", 72'(mif.cnt_out), 72'd1);
    end
    mif.out_ready = 1'b1;
    step();
    check("bp_release_valid", 72'(mif.out_valid), 72'd0);
    check("bp_release_ready", 72'(mif.prod_ready), 72'd1);
    step();
    check("bp_held_valid", 72'(mif.out_valid), 72'd1);
    check("bp_held_acc", mif.acc_out, 72'd11);
    check("bp_held_cnt", 72'(mif.cnt_out), 72'd1);
    mif.prod_valid = 1'b0;
    step();

    // Reset mid-packet discards the partial sum and never presents a result.
    apply(mk(5, 0, 0, 5,  1));
    apply(mk(6, 0, 0, 11, 2));
    rst = 1'b1;
    #1;
    check("mid_rst_acc", mif.acc_out, 72'd0);
    check("mid_rst_cnt", 72'(mif.cnt_out), 72'd0);
    check("mid_rst_ready", 72'(mif.prod_ready), 72'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_out_valid", 72'(mif.out_valid), 72'd0);
    end
    apply(mk(90, 1, 0, 90, 1));
    step();

    foreach (tbl64[i]) apply64(tbl64[i]);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
